// File: rtl/midi_note_tx.sv
// MIDI OUT transmitter: sends one 3-byte channel-voice message (status, note,
// velocity) as 8N1 serial, LSB first, idle high, CLKS_PER_BIT clocks per bit.
// GAP_BITS idle-high bit times may be inserted after each stop bit.
module midi_note_tx #(
  parameter int CLKS_PER_BIT = 128,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  // The cycle counter must reach both one bit time and the whole gap time.
  localparam int GAP_MULT = (GAP_BITS > 1) ? GAP_BITS : 1;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT * GAP_MULT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLKS_PER_BIT * GAP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [1:0]       byte_idx, byte_n;
  logic [23:0]      msg, msg_n;
  logic             data_n, busy_n, done_n;
  logic [7:0]       cur_byte;
  logic [2:0]       next_bit;
  logic             byte_end;

  // Pick the byte currently on the wire from the latched message.
  always_comb begin
    cur_byte = msg[7:0];
    case (byte_idx)
      2'd0:    cur_byte = msg[23:16];
      2'd1:    cur_byte = msg[15:8];
      default: cur_byte = msg[7:0];
    endcase
  end

  // Next-state and registered-output logic; every line transition lands on a bit boundary.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    msg_n    = msg;
    data_n   = data_out;
    busy_n   = busy;
    done_n   = 1'b0;
    byte_end = 1'b0;
    next_bit = bit_idx + 3'd1;

    case (state)
      IDLE: begin
        if (send) begin
          msg_n   = {1'b1, 2'b00, note_on, channel, 1'b0, note, 1'b0, velocity};
          state_n = START;
          cnt_n   = '0;
          bit_n   = 3'd0;
          byte_n  = 2'd0;
          data_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (cnt == BIT_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = 3'd0;
          data_n  = cur_byte[0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            data_n  = 1'b1;
          end else begin
            bit_n  = next_bit;
            data_n = cur_byte[next_bit];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (GAP_BITS > 0) begin
            state_n = GAP;
          end else begin
            byte_end = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n    = '0;
          byte_end = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        data_n  = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // After a byte's stop (and gap) either start the next byte or finish.
    if (byte_end) begin
      if (byte_idx == 2'd2) begin
        state_n = IDLE;
        byte_n  = 2'd0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        state_n = START;
        byte_n  = byte_idx + 2'd1;
        data_n  = 1'b0;
      end
    end
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      msg      <= '0;
      data_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      msg      <= msg_n;
      data_out <= data_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_midi_note_tx.sv
// Bench for midi_note_tx: a serial-line decoder pops expected bytes and
// completion cycles from scoreboard queues filled when messages are sent.
module tb_midi_note_tx;

  localparam int C = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic       send_gap = 1'b0;
  logic       note_on = 1'b0;
  logic [3:0] channel = 4'd0;
  logic [6:0] note = 7'd0;
  logic [6:0] velocity = 7'd0;
  logic       data_out, busy, done;
  logic       gdata_out, gbusy, gdone;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_byte_t;

  exp_byte_t bq[$];
  int        dq[$];
  int        cyc = 0;
  int        passes = 0;
  int        total = 0;
  int        t, t2, tg;

  bit         mon_active = 1'b0;
  int         mon_start, mon_pos, mon_k, exp_done;
  logic [7:0] mon_shift;
  exp_byte_t  e;
  logic [7:0] gb [3];

  midi_note_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut (
    .clk(clk), .reset(reset), .send(send), .note_on(note_on), .channel(channel),
    .note(note), .velocity(velocity), .data_out(data_out), .busy(busy), .done(done)
  );

  midi_note_tx #(.CLKS_PER_BIT(C), .GAP_BITS(2)) dut_gap (
    .clk(clk), .reset(reset), .send(send_gap), .note_on(note_on), .channel(channel),
    .note(note), .velocity(velocity), .data_out(gdata_out), .busy(gbusy), .done(gdone)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge P the value is P.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] msgByte(input int i, input bit on, input logic [3:0] ch,
                                         input logic [6:0] nt, input logic [6:0] vel);
    case (i)
      0:       return (on ? 8'h90 : 8'h80) | {4'h0, ch};
      1:       return {1'b0, nt};
      default: return {1'b0, vel};
    endcase
  endfunction

  task automatic pushMessage(input bit on, input logic [3:0] ch, input logic [6:0] nt,
                             input logic [6:0] vel, input int tacc);
    exp_byte_t x;
    for (int i = 0; i < 3; i++) begin
      x.data  = msgByte(i, on, ch, nt, vel);
      x.start = tacc + i * 10 * C;
      bq.push_back(x);
    end
    dq.push_back(tacc + 30 * C);
  endtask

  // Drive a one-cycle send (or leave it held) and record the acceptance edge.
  task automatic applyStimulus(input bit on, input logic [3:0] ch, input logic [6:0] nt,
                               input logic [6:0] vel, input bit hold, output int tacc);
    @(posedge clk);
    #1;
    note_on  = on;
    channel  = ch;
    note     = nt;
    velocity = vel;
    send     = 1'b1;
    tacc     = cyc + 1;
    pushMessage(on, ch, nt, vel, tacc);
    @(posedge clk);
    #1;
    if (!hold) send = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Line decoder: finds a start edge, samples mid-bit, checks framing, pops expected byte.
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (data_out === 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        mon_shift  = 8'h00;
      end
    end else begin
      mon_pos = cyc - mon_start;
      if (mon_pos % C == C / 2) begin
        mon_k = mon_pos / C;
        if (mon_k == 0) begin
          checkOutput("start_bit", 32'(data_out), 32'd0);
        end else if (mon_k <= 8) begin
          mon_shift[mon_k-1] = data_out;
        end else begin
          checkOutput("stop_bit", 32'(data_out), 32'd1);
          if (bq.size() == 0) begin
            checkOutput("byte_unexpected", 32'(bq.size()), 32'd1);
          end else begin
            e = bq.pop_front();
            checkOutput("byte_value", 32'(mon_shift), 32'(e.data));
            checkOutput("byte_start_cycle", mon_start, e.start);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // Completion monitor: every done pulse must match a scheduled completion cycle.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (dq.size() == 0) begin
        checkOutput("done_unexpected", 32'(done), 32'd0);
      end else begin
        exp_done = dq.pop_front();
        checkOutput("done_cycle", cyc, exp_done);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_data_out", 32'(data_out), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_gap_data_out", 32'(gdata_out), 32'd1);

    // Note On, ch 0, note 60, velocity 100
    $display("[TB] note on ch0 60/100");
    applyStimulus(1'b1, 4'd0, 7'd60, 7'd100, 1'b0, t);
    @(negedge clk);
    checkOutput("t1_busy_at_T", 32'(busy), 32'd1);
    checkOutput("t1_start_at_T", 32'(data_out), 32'd0);
    waitUntil(t + 3839);
    checkOutput("t1_busy_last", 32'(busy), 32'd1);
    waitUntil(t + 3840);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_done_end", 32'(done), 32'd1);
    waitUntil(t + 3841);
    checkOutput("t1_done_low", 32'(done), 32'd0);
    checkOutput("t1_idle_line", 32'(data_out), 32'd1);

    // Note Off, ch 5, 127/0, re-send with changed inputs mid-message
    $display("[TB] note off ch5 127/0 with re-send");
    applyStimulus(1'b0, 4'd5, 7'd127, 7'd0, 1'b0, t);
    waitUntil(t + 499);
    send     = 1'b1;
    note_on  = 1'b1;
    channel  = 4'd3;
    note     = 7'd1;
    velocity = 7'd2;
    @(negedge clk);
    send = 1'b0;
    checkOutput("t2_busy_mid", 32'(busy), 32'd1);
    waitUntil(t + 3840);
    checkOutput("t2_done", 32'(done), 32'd1);
    waitUntil(t + 3845);
    checkOutput("t2_no_restart", 32'(busy), 32'd0);

    // Reset mid-message, then a full frame
    $display("[TB] reset mid-message");
    applyStimulus(1'b1, 4'd2, 7'd64, 7'd64, 1'b0, t);
    waitUntil(t + 998);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t3_rst_data_out", 32'(data_out), 32'd1);
    checkOutput("t3_rst_busy", 32'(busy), 32'd0);
    bq.delete();
    dq.delete();
    repeat (300) @(negedge clk);
    checkOutput("t3_still_idle", 32'(busy), 32'd0);
    applyStimulus(1'b1, 4'd15, 7'd1, 7'd85, 1'b0, t);
    waitUntil(t + 3845);
    checkOutput("t3_after_busy", 32'(busy), 32'd0);

    // Back-to-back: send held through the done cycle
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 4'd7, 7'd36, 7'd127, 1'b1, t);
    note_on  = 1'b0;
    channel  = 4'd10;
    note     = 7'd90;
    velocity = 7'd33;
    t2 = t + 30 * C + 1;
    pushMessage(1'b0, 4'd10, 7'd90, 7'd33, t2);
    waitUntil(t + 3840);
    checkOutput("t4_done", 32'(done), 32'd1);
    @(posedge clk);
    #1 send = 1'b0;
    @(negedge clk);
    checkOutput("t4_second_start", 32'(data_out), 32'd0);
    checkOutput("t4_second_busy", 32'(busy), 32'd1);
    waitUntil(t2 + 3845);
    checkOutput("t4_final_busy", 32'(busy), 32'd0);

    // Two gap bits after every stop bit
    $display("[TB] gap build");
    @(posedge clk);
    #1;
    note_on  = 1'b1;
    channel  = 4'd9;
    note     = 7'h2A;
    velocity = 7'h15;
    send_gap = 1'b1;
    tg = cyc + 1;
    for (int i = 0; i < 3; i++) gb[i] = msgByte(i, 1'b1, 4'd9, 7'h2A, 7'h15);
    @(posedge clk);
    #1 send_gap = 1'b0;
    for (int k = 0; k < 36; k++) begin
      waitUntil(tg + k * C + C / 2);
      if (k % 12 == 0) checkOutput("gap_start_bit", 32'(gdata_out), 32'd0);
      else if (k % 12 <= 8) checkOutput("gap_data_bit", 32'(gdata_out), 32'(gb[k/12][k%12-1]));
      else checkOutput("gap_idle_bit", 32'(gdata_out), 32'd1);
    end
    waitUntil(tg + 4607);
    checkOutput("gap_busy_last", 32'(gbusy), 32'd1);
    checkOutput("gap_no_early_done", 32'(gdone), 32'd0);
    waitUntil(tg + 4608);
    checkOutput("gap_done", 32'(gdone), 32'd1);
    checkOutput("gap_busy_end", 32'(gbusy), 32'd0);
    waitUntil(tg + 4609);
    checkOutput("gap_done_low", 32'(gdone), 32'd0);

    repeat (5) @(negedge clk);
    checkOutput("bytes_drained", 32'(bq.size()), 32'd0);
    checkOutput("dones_drained", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
